bcd2bin_load_2dig: RTL
======================

# bcd2bin_load_2dig

Two-digit BCD-to-binary loader: the inverse of the 2-digit up/down BCD counters used for time fields. It accepts a tens/units BCD pair (e.g. read back from the RTC or the keypad path), validates it, and converts it serially (reverse double-dabble, one bit per clock) into an N-bit binary value. It range-checks the result and presents it with a one-cycle `done` pulse, so a counter register can be loaded from it. One instance per time field (seconds/minutes 0–59, hours 0–23).

## Interface
- `N`, 6 — binary output width.
- `MAX`, 59 — largest legal value; values above it are out of range.
- `SEL`, 4'd9 — `en_count` code that selects this field.
- `clk` input 1 — single clock; all logic on rising edge.
- `reset` input 1 — synchronous, active-high.
- `en_count` input 4 — field select; a load is accepted only when equal to `SEL`.
- `load` input 1 — level request; its rising edge is detected internally.
- `digit1` input 4 — tens BCD digit.
- `digit0` input 4 — units BCD digit.
- `bin_out` output N — last accepted binary value; registered.
- `busy` output 1 — high from the cycle after acceptance through the cycle `done` pulses.
- `done` output 1 — one-cycle pulse when a conversion completes.
- `err` output 1 — registered alongside `done`; high if the last load had an invalid digit or an out-of-range value.

## Operation
- Edge detect:
  - `load_tick = load & ~load_reg`.
  - `load_reg` is set to 1 by reset, so a `load` held high through reset does not trigger.
- States: IDLE, CHECK, CONV, DONE.
- **IDLE.** On `load_tick && en_count == SEL`:
  - Capture `{digit1, digit0}` into the 8-bit shift register `bcd_sh`.
  - Clear the 8-bit `bin_sh`.
  - Go to CHECK.
  - Ticks with any other `en_count` are ignored.
- **CHECK.**
  - If either captured nibble is greater than 9: set the `bad_digit` flag and go to DONE (no conversion).
  - Otherwise: load `iter = 0` and go to CONV.
- **CONV.** Each cycle:
  - Shift `{bcd_sh, bin_sh}` right by 1.
  - Then, in each of the two `bcd_sh` nibbles, subtract 3 from any nibble that is ≥ 8.
  - `iter` increments; after the 8th iteration (`iter == 7`), go to DONE.
- **DONE.** For one cycle: assert `done`, update `err`, and return to IDLE.
  - Value = `bin_sh` (8 bits, 0–99).
  - Valid (no bad digit and value ≤ MAX): `bin_out <= value[N-1:0]`, `err <= 0`.
  - Bad digit: `bin_out` unchanged, `err <= 1`.
  - Out of range: `err <= 1`; `bin_out` handling per Configuration.
- Range compare uses the full 8-bit value, never the truncated N bits.
- Load ticks arriving while `busy` are dropped; they are not queued.
- `err` holds its value until the next DONE.

## Timing
- Reset values: `bin_out = 0`, `busy = 0`, `done = 0`, `err = 0`, state IDLE, `iter = 0`, `load_reg = 1`.
- Reset mid-conversion aborts immediately: no `done` pulse, `bin_out` returns to 0.
- With the accepted tick at cycle T:
  - CHECK at T+1.
  - CONV at T+2..T+9.
  - DONE at T+10 (`done` high, `bin_out`/`err` valid in that cycle).
  - Back in IDLE at T+11.
  - Latency is 10 cycles.
- Bad-digit path: DONE at T+2, latency 2 cycles.
- `busy` is high T+1 through the DONE cycle inclusive.
- Maximum acceptance rate: one load per 11 cycles; a new tick is accepted in the first IDLE cycle after DONE.
- A tick coincident with `done` is dropped.
- `done` never stays high for two consecutive cycles.

## Configuration
- `BCD2BIN_SATURATE_EN` defined: an out-of-range value sets `bin_out <= MAX` with `err <= 1`.
- Not defined: on out of range, `bin_out` keeps its previous value and `err <= 1`.
- Both builds treat a bad digit identically: `bin_out` unchanged, `err = 1`.

## Test plan
- Reset, then `en_count = 9`, digits 5/9, pulse `load` → `done` 10 cycles after the tick; `bin_out = 59`; `err = 0`; `busy` high 10 cycles.
- Digits 0/7, then 4/2 (second load after `done`) → `bin_out = 7`, then `bin_out = 42`; two `done` pulses 11 cycles apart.
- Digits 7/3 with `bin_out = 42` → `err = 1`; `bin_out = 59` with `BCD2BIN_SATURATE_EN`, stays 42 without.
- Digits 1/12 → `done` 2 cycles after the tick; `err = 1`; `bin_out` unchanged. Then digits 0/0 → `bin_out = 0`, `err = 0`.
- `en_count = 5` with a `load` pulse → no `busy`, no `done`. A second `load` edge at T+4 during a valid conversion → ignored; exactly one `done`.
- Hold `load` high across reset → no conversion after reset. Assert `reset` at T+6 of a conversion → all outputs 0 next cycle and no `done`.

Source files
------------

// File: rtl/bcd2bin_load_2dig.sv
// Two-digit BCD-to-binary loader: validates a tens/units pair and converts it serially into an N-bit value with range check.
// Optional feature macro BCD2BIN_SATURATE_EN: out-of-range results load MAX instead of holding the previous value.
module bcd2bin_load_2dig #(
    parameter int         N   = 6,
    parameter int         MAX = 59,
    parameter logic [3:0] SEL = 4'd9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   en_count,
    input  logic         load,
    input  logic [3:0]   digit1,
    input  logic [3:0]   digit0,
    output logic [N-1:0] bin_out,
    output logic         busy,
    output logic         done,
    output logic         err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_CONV  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] MAX_8 = MAX[7:0];
`ifdef BCD2BIN_SATURATE_EN
    localparam logic [N-1:0] MAX_N = MAX[N-1:0];
`endif

    state_t       state_r, state_s;
    logic         load_reg_r;
    logic         load_tick_s;
    logic [7:0]   bcd_sh_r, bcd_sh_s;
    logic [7:0]   bin_sh_r, bin_sh_s;
    logic [15:0]  shift_s;
    logic [2:0]   iter_r, iter_s;
    logic         bad_digit_s;
    logic [N-1:0] bin_out_r, bin_out_s;
    logic         err_r, err_s;
    logic         done_r, busy_r;

    // Reverse double-dabble correction: a nibble >= 8 after the shift carried a tens bit worth 5, not 8.
    function automatic logic [3:0] nibble_fix(input logic [3:0] nib);
        logic [3:0] res;
        if (nib >= 4'd8) begin
            res = nib - 4'd3;
        end else begin
            res = nib;
        end
        return res;
    endfunction

    assign bin_out = bin_out_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign err     = err_r;

    // Next-state, datapath and result computation; results are captured on entry to DONE so they are valid in that cycle.
    always_comb begin
        state_s     = state_r;
        bcd_sh_s    = bcd_sh_r;
        bin_sh_s    = bin_sh_r;
        iter_s      = iter_r;
        bin_out_s   = bin_out_r;
        err_s       = err_r;
        load_tick_s = load & ~load_reg_r;
        shift_s     = {bcd_sh_r, bin_sh_r} >> 1;
        bad_digit_s = (bcd_sh_r[7:4] > 4'd9) || (bcd_sh_r[3:0] > 4'd9);

        case (state_r)
            S_IDLE: begin
                if (load_tick_s && (en_count == SEL)) begin
                    bcd_sh_s = {digit1, digit0};
                    bin_sh_s = 8'd0;
                    state_s  = S_CHECK;
                end else begin
                    state_s  = S_IDLE;
                end
            end
            S_CHECK: begin
                if (bad_digit_s) begin
                    err_s   = 1'b1;
                    state_s = S_DONE;
                end else begin
                    iter_s  = 3'd0;
                    state_s = S_CONV;
                end
            end
            S_CONV: begin
                bcd_sh_s = {nibble_fix(shift_s[15:12]), nibble_fix(shift_s[11:8])};
                bin_sh_s = shift_s[7:0];
                iter_s   = iter_r + 3'd1;
                if (iter_r == 3'd7) begin
                    state_s = S_DONE;
                    // Range check on the full 8-bit value so truncation cannot hide an overflow.
                    if (bin_sh_s > MAX_8) begin
                        err_s = 1'b1;
`ifdef BCD2BIN_SATURATE_EN
                        bin_out_s = MAX_N;
`else
                        bin_out_s = bin_out_r;
`endif
                    end else begin
                        err_s     = 1'b0;
                        bin_out_s = bin_sh_s[N-1:0];
                    end
                end else begin
                    state_s = S_CONV;
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= S_IDLE;
            load_reg_r <= 1'b1;
            bcd_sh_r   <= 8'd0;
            bin_sh_r   <= 8'd0;
            iter_r     <= 3'd0;
            bin_out_r  <= '0;
            err_r      <= 1'b0;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            load_reg_r <= load;
            bcd_sh_r   <= bcd_sh_s;
            bin_sh_r   <= bin_sh_s;
            iter_r     <= iter_s;
            bin_out_r  <= bin_out_s;
            err_r      <= err_s;
            done_r     <= (state_s == S_DONE);
            busy_r     <= (state_s != S_IDLE);
        end
    end

endmodule
